// File: rtl/fwd_stall_unit.sv
// fwd_stall_unit: EX..WB write shadow driving ALU forward selects and the load-use ID stall/EX bubble.
// Latency: selects and stall are combinational from registered shadow state; hold freezes everything, id_stall is the only backpressure.
module fwd_stall_unit #(
  parameter  int REG_AW     = 5,
  parameter  int NUM_STAGES = 3,
  parameter  int LOAD_READY = 2,
  parameter  int CNT_W      = 16,
  localparam int SEL_W      = $clog2(NUM_STAGES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_is_load,
  input  logic              hold,
  input  logic              flush,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [SEL_W-1:0]  fwd_a,
  output logic [SEL_W-1:0]  fwd_b,
  output logic [CNT_W-1:0]  stall_count
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              load;
  } entry_t;

  entry_t            stage_q [NUM_STAGES];
  logic [REG_AW-1:0] ex_rs_q;
  logic [REG_AW-1:0] ex_rt_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic [NUM_STAGES-1:0] live;
  logic                  stall_a;
  logic                  stall_b;
  logic                  accept;
  entry_t                id_entry;

  function automatic int ready_stage(input logic is_load);
    return is_load ? LOAD_READY : 1;
  endfunction

  always_comb begin
    live = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      live[s] = stage_q[s].valid && stage_q[s].regwrite && (stage_q[s].rd != '0);
    end
  end

  // Descending scan: the last match written is the youngest producer.
  // Register 0 never matches because a live producer has a nonzero rd.
  always_comb begin
    stall_a = 1'b0;
    stall_b = 1'b0;
    for (int s = NUM_STAGES - 2; s >= 0; s--) begin
      if (live[s] && (stage_q[s].rd == id_rs)) begin
        stall_a = (s + 1) < ready_stage(stage_q[s].load);
      end
      if (live[s] && (stage_q[s].rd == id_rt)) begin
        stall_b = (s + 1) < ready_stage(stage_q[s].load);
      end
    end
  end

  assign id_stall = id_valid && !flush && (stall_a || stall_b);
  assign accept   = id_valid && !flush && !id_stall;

  always_comb begin
    id_entry = '0;
    if (accept) begin
      id_entry.valid    = 1'b1;
      id_entry.rd       = id_rd;
      id_entry.regwrite = id_regwrite;
      id_entry.load     = id_is_load;
    end
  end

  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    if (stage_q[0].valid) begin
      for (int s = NUM_STAGES - 1; s >= 1; s--) begin
        if (live[s] && (stage_q[s].rd == ex_rs_q)) fwd_a = SEL_W'(s);
        if (live[s] && (stage_q[s].rd == ex_rt_q)) fwd_b = SEL_W'(s);
      end
    end
  end

  // Source operands are only ever compared in EX, so they are kept for stage 0 only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_STAGES; k++) stage_q[k] <= '0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      stall_cnt_q <= '0;
    end else if (!hold) begin
      for (int k = 1; k < NUM_STAGES; k++) stage_q[k] <= stage_q[k-1];
      stage_q[0] <= id_entry;
      ex_rs_q    <= accept ? id_rs : '0;
      ex_rt_q    <= accept ? id_rt : '0;
      if (id_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign ex_valid    = stage_q[0].valid;
  assign stall_count = stall_cnt_q;

endmodule
